// File: rtl/mm_pkg.sv
// mm_pkg: shared FSM states, bank geometry helpers and channel skew for mem_read/mem_write.
// Define MEM_READ_SKEW_EN to stagger channel k by k cycles; undefined gives lockstep channels.
package mm_pkg;
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
`ifdef MEM_READ_SKEW_EN
  localparam int SKEW_EN = 1;
`else
  localparam int SKEW_EN = 0;
`endif
  function automatic int depth(input int m, input int n);
    return (m * m) / n;
  endfunction
  function automatic int addr_w(input int m, input int n);
    return depth(m, n) > 1 ? $clog2(depth(m, n)) : 1;
  endfunction
  function automatic int skew(input int k);
    return k * SKEW_EN;
  endfunction
endpackage

// File: rtl/mem_read_if.sv
// mem_read_if: start/status handshake plus packed per-channel BRAM read and output stream.
interface mem_read_if #(parameter int N = 3, parameter int D_W = 32, parameter int A_W = 4);
  logic           start;
  logic [N-1:0]     rd_en_bram;
  logic [N*A_W-1:0] rd_addr_bram;
  logic [N*D_W-1:0] rd_data_bram;
  logic [N*D_W-1:0] out_data;
  logic [N-1:0]     out_valid;
  logic           busy;
  logic           done;
  modport master (output start, rd_data_bram,
                  input rd_en_bram, rd_addr_bram, out_data, out_valid, busy, done);
  modport slave  (input start, rd_data_bram,
                  output rd_en_bram, rd_addr_bram, out_data, out_valid, busy, done);
endinterface

// File: rtl/mem_rd_pipe.sv
// mem_rd_pipe: W-bit valid delay line of LAT stages with synchronous clear.
module mem_rd_pipe #(parameter int W = 3, parameter int LAT = 1) (
  input  logic         clk,
  input  logic         clr,
  input  logic [W-1:0] in_v,
  output logic [W-1:0] out_v
);
  logic [LAT-1:0][W-1:0] stg_q, stg_d;
  always_comb begin
    stg_d[0] = in_v;
    for (int i = 1; i < LAT; i++) stg_d[i] = stg_q[i-1];
  end
  always_ff @(posedge clk) stg_q <= clr ? '0 : stg_d;
  assign out_v = stg_q[LAT-1];
endmodule

// File: rtl/mem_read.sv
// mem_read: streams every BRAM bank once per start, channel k delayed by skew(k) (MEM_READ_SKEW_EN).
module mem_read import mm_pkg::*; #(
  parameter int D_W    = 32,
  parameter int N      = 3,
  parameter int M      = 6,
  parameter int RD_LAT = 1
) (
  input logic       clk,
  input logic       rst,
  mem_read_if.slave bus
);
  localparam int DEPTH = depth(M, N);
  localparam int A_W   = addr_w(M, N);
  localparam int LAST  = skew(N-1) + DEPTH + RD_LAT;
  localparam int CW    = $clog2(LAST + 1);
  localparam logic [CW-1:0] LAST_RD = CW'(skew(N-1) + DEPTH - 1);
  localparam logic [CW-1:0] DONE_T  = CW'(LAST - 1);
  localparam logic [CW-1:0] END_T   = CW'(LAST);
  if (RD_LAT < 1 || RD_LAT > 4 || D_W < 1) begin : g_bad_cfg
    $error("mem_read: RD_LAT must be 1..4 and D_W positive");
  end
  state_t                state_q, state_d;
  logic [CW-1:0]         cyc_q, cyc_d;
  logic [N-1:0][A_W-1:0] addr_q, addr_d;
  logic [N-1:0]          en_q, en_d;
  logic                  busy_q, busy_d, done_q, done_d;
  // cyc_q counts cycles since start acceptance; all windows and exits are decoded from it
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    addr_d  = addr_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (state_q == IDLE && bus.start) begin
      state_d = READ;
      cyc_d   = '0;
      addr_d  = '0;
      busy_d  = 1'b1;
    end else if (state_q != IDLE) begin
      cyc_d = cyc_q + CW'(1);
      if (state_q == READ && cyc_q == LAST_RD) state_d = DRAIN;
      if (state_q == DRAIN && cyc_q == DONE_T) begin
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      if (state_q == DRAIN && cyc_q == END_T) state_d = IDLE;
    end
    // unsigned wrap makes cycles before the skew offset fall outside the window
    for (int k = 0; k < N; k++) begin
      if (en_q[k] && addr_q[k] != A_W'(DEPTH - 1)) addr_d[k] = addr_q[k] + A_W'(1);
      en_d[k] = state_d == READ && (cyc_d - CW'(skew(k))) < CW'(DEPTH);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      addr_q  <= '0;
      en_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      addr_q  <= addr_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  mem_rd_pipe #(.W(N), .LAT(RD_LAT)) u_pipe (
    .clk  (clk),
    .clr  (rst),
    .in_v (en_q),
    .out_v(bus.out_valid)
  );
  assign bus.rd_en_bram   = en_q;
  assign bus.rd_addr_bram = addr_q;
  assign bus.out_data     = bus.rd_data_bram;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
endmodule

// File: tb/tb_mem_read.sv
// tb_mem_read: directed checks of mem_read with RD_LAT=1 and RD_LAT=3 instances side by side.
module tb_mem_read;
  localparam int N = 3, M = 6, D_W = 32, DEPTH = 12, A_W = 4;
`ifdef MEM_READ_SKEW_EN
  localparam int SK = 1;
`else
  localparam int SK = 0;
`endif
  localparam int DONE0 = 1 + SK * (N - 1) + DEPTH + 1;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  mem_read_if #(.N(N), .D_W(D_W), .A_W(A_W)) b0 (), b1 ();
  assign b0.start = start;
  assign b1.start = start;
  mem_read #(.D_W(D_W), .N(N), .M(M), .RD_LAT(1)) u0 (.clk(clk), .rst(rst), .bus(b0.slave));
  mem_read #(.D_W(D_W), .N(N), .M(M), .RD_LAT(3)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
  // BRAM models: bank k holds 100*k+addr, returned RD_LAT cycles after the address
  logic [A_W-1:0] h0 [N];
  logic [A_W-1:0] h1 [N][3];
  always @(posedge clk)
    for (int k = 0; k < N; k++) begin
      h0[k]    <= b0.rd_addr_bram[k*A_W +: A_W];
      h1[k][0] <= b1.rd_addr_bram[k*A_W +: A_W];
      h1[k][1] <= h1[k][0];
      h1[k][2] <= h1[k][1];
    end
  always_comb begin
    b0.rd_data_bram = '0;
    b1.rd_data_bram = '0;
    for (int k = 0; k < N; k++) begin
      b0.rd_data_bram[k*D_W +: D_W] = D_W'(100 * k) + D_W'(h0[k]);
      b1.rd_data_bram[k*D_W +: D_W] = D_W'(100 * k) + D_W'(h1[k][2]);
    end
  end
  int en_first[2][N], en_last[2][N], en_cnt[2][N];
  int ov_first[2][N], ov_last[2][N], ov_cnt[2][N];
  int done_cnt[2], done_at[2], seq_err[2], addr_err[2], post_act[2], busy1[2], busy_done[2];
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic run(input int ncyc, input int rs1, input int rs2, input int rst_at);
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < N; k++) begin
        en_first[d][k] = -1; en_last[d][k] = -1; en_cnt[d][k] = 0;
        ov_first[d][k] = -1; ov_last[d][k] = -1; ov_cnt[d][k] = 0;
      end
      done_cnt[d] = 0; done_at[d] = -1; seq_err[d] = 0; addr_err[d] = 0;
      post_act[d] = 0; busy1[d] = -1; busy_done[d] = -1;
    end
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      for (int d = 0; d < 2; d++) begin
        logic [N-1:0] en, ov;
        logic [N*A_W-1:0] ad;
        logic [N*D_W-1:0] dt;
        logic dn, bz;
        en = d == 1 ? b1.rd_en_bram : b0.rd_en_bram;
        ov = d == 1 ? b1.out_valid : b0.out_valid;
        ad = d == 1 ? b1.rd_addr_bram : b0.rd_addr_bram;
        dt = d == 1 ? b1.out_data : b0.out_data;
        dn = d == 1 ? b1.done : b0.done;
        bz = d == 1 ? b1.busy : b0.busy;
        if (c == 1) busy1[d] = int'(bz);
        for (int k = 0; k < N; k++) begin
          if (en[k]) begin
            if (en_first[d][k] < 0) en_first[d][k] = c;
            en_last[d][k] = c;
            if (int'(ad[k*A_W +: A_W]) != en_cnt[d][k]) addr_err[d]++;
            en_cnt[d][k]++;
          end
          if (ov[k]) begin
            if (ov_first[d][k] < 0) ov_first[d][k] = c;
            ov_last[d][k] = c;
            if (dt[k*D_W +: D_W] != D_W'(100 * k + ov_cnt[d][k])) seq_err[d]++;
            ov_cnt[d][k]++;
          end
        end
        if (dn) begin
          done_cnt[d]++;
          done_at[d] = c;
          busy_done[d] = int'(bz);
        end
        if (rst_at > 0 && c > rst_at && (en != '0 || ov != '0 || dn || bz)) post_act[d]++;
      end
      start = c == rs1 || c == rs2;
      rst   = c == rst_at;
      step();
    end
    rst = 1'b0;
    start = 1'b0;
  endtask
  task automatic verify(input string nm, input int d);
    int lat;
    lat = d == 1 ? 3 : 1;
    chk({nm, "_en0_first"}, en_first[d][0], 1);
    chk({nm, "_en0_last"}, en_last[d][0], DEPTH);
    chk({nm, "_enN_first"}, en_first[d][N-1], 1 + SK * (N - 1));
    chk({nm, "_enN_last"}, en_last[d][N-1], DEPTH + SK * (N - 1));
    chk({nm, "_enN_cnt"}, en_cnt[d][N-1], DEPTH);
    chk({nm, "_ov0_first"}, ov_first[d][0], 1 + lat);
    chk({nm, "_ovN_first"}, ov_first[d][N-1], 1 + SK * (N - 1) + lat);
    chk({nm, "_ovN_last"}, ov_last[d][N-1], DEPTH + SK * (N - 1) + lat);
    chk({nm, "_ov0_cnt"}, ov_cnt[d][0], DEPTH);
    chk({nm, "_done_cnt"}, done_cnt[d], 1);
    chk({nm, "_done_at"}, done_at[d], 1 + SK * (N - 1) + DEPTH + lat);
    chk({nm, "_seq_err"}, seq_err[d], 0);
    chk({nm, "_addr_err"}, addr_err[d], 0);
    chk({nm, "_busy_c1"}, busy1[d], 1);
    chk({nm, "_busy_at_done"}, busy_done[d], 0);
  endtask
  initial begin
    rst = 1'b1;
    start = 1'b1;
    repeat (3) step();
    chk("rst_en", int'(b0.rd_en_bram), 0);
    chk("rst_addr", int'(b0.rd_addr_bram), 0);
    chk("rst_ov", int'(b1.out_valid), 0);
    chk("rst_busy", int'(b0.busy), 0);
    chk("rst_done", int'(b1.done), 0);
    start = 1'b0;
    rst = 1'b0;
    step();
    chk("idle_busy", int'(b0.busy), 0);
    chk("idle_en", int'(b1.rd_en_bram), 0);
    step();
    run(25, 5, 10, 0);
    verify("repulse_l1", 0);
    verify("repulse_l3", 1);
    run(DONE0, 0, 0, 0);
    verify("b2b_first", 0);
    run(25, 0, 0, 0);
    verify("b2b_second", 0);
    run(25, 0, 0, 7);
    chk("abort_en_started", en_first[0][0], 1);
    chk("abort_done_l1", done_cnt[0], 0);
    chk("abort_done_l3", done_cnt[1], 0);
    chk("abort_quiet_l1", post_act[0], 0);
    chk("abort_quiet_l3", post_act[1], 0);
    run(25, 0, 0, 0);
    verify("restart_l1", 0);
    verify("restart_l3", 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
